// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//
// Elastic chain of STAGES pipeline registers, each WIDTH bits wide with its own
// valid bit. Stages advance on a valid/ready handshake, so a stall at the output
// only backs up the stages that are actually occupied behind it; empty stages
// keep moving and bubbles collapse toward the output. A per-stage flush mask
// turns wrong-path entries into NOP bubbles in the same cycle.
//
// Parameters
//   WIDTH   payload width in bits (>= 1)
//   STAGES  number of register stages (>= 1)
//   NOP     payload held by an empty stage (truncated/zero-extended to WIDTH)
//   CW      occupancy counter width (derived, leave at default)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   in_valid    upstream presents in_data
//   in_ready    stage 0 can accept this cycle
//   in_data     upstream payload
//   out_valid   last stage holds a live entry
//   out_ready   downstream consumes this cycle
//   out_data    last-stage payload, NOP when out_valid is low
//   flush_mask  bit i set: discard the entry held in stage i this cycle
//   occupancy   registered count of valid stages
// -----------------------------------------------------------------------------
module pipe_chain #(
    parameter int          WIDTH  = 32,
    parameter int          STAGES = 4,
    parameter logic [31:0] NOP    = 32'h0000_0013,
    parameter int          CW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic [STAGES-1:0] flush_mask,
    output logic [CW-1:0]     occupancy
);

    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CW-1:0]     occupancy_q;
    logic [CW-1:0]     occupancy_d;

    logic [STAGES-1:0] live;
    logic [STAGES-1:0] rdy;
    logic              accept;
    logic              emit;

    // A flushed entry is already absent in the cycle it is flushed, so it
    // neither blocks the stages behind it nor gets emitted.
    assign live = valid_q & ~flush_mask;

    // Ready ripples from the output side: a stage can load whenever it is
    // empty (or being flushed) or the stage ahead of it is moving.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = ~live[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            rdy[i] = ~live[i] | rdy[i+1];
        end
    end

    assign in_ready  = rdy[0];
    assign accept    = in_valid & rdy[0];
    assign out_valid = live[STAGES-1];
    assign emit      = live[STAGES-1] & out_ready;
    assign out_data  = live[STAGES-1] ? data_q[STAGES-1] : NOP_W;
    assign occupancy = occupancy_q;

    // Next-state per stage. Any stage that ends up empty is rewritten with NOP
    // so flushed or drained payloads never linger in the datapath.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (rdy[0]) begin
            valid_d[0] = accept;
            data_d[0]  = accept ? in_data : NOP_W;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
                valid_d[i] = live[i-1];
                data_d[i]  = live[i-1] ? data_q[i-1] : NOP_W;
            end
        end
    end

    // Occupancy bookkeeping. A flushed last-stage entry is not live, so it can
    // never also be counted as emitted. One extra bit keeps the intermediate
    // sum from wrapping before the subtraction.
    logic [CW:0] flush_cnt;
    logic [CW:0] occ_sum;

    always_comb begin
        flush_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            flush_cnt = flush_cnt + {{CW{1'b0}}, valid_q[i] & flush_mask[i]};
        end
        occ_sum = {1'b0, occupancy_q}
                + {{CW{1'b0}}, accept}
                - {{CW{1'b0}}, emit}
                - flush_cnt;
        occupancy_d = occ_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= NOP_W;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//
// Directed bench for pipe_chain (WIDTH=32, STAGES=4): streaming, backpressure,
// bubble collapse, partial flush, full flush with same-cycle accept, and
// asynchronous reset mid-stream. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled after the inputs have settled.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

    localparam int          WIDTH  = 32;
    localparam int          STAGES = 4;
    localparam int          CW     = $clog2(STAGES + 1);
    localparam logic [31:0] NOPV   = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [STAGES-1:0] flush_mask;
    logic [CW-1:0]     occupancy;

    int checks;
    int errors;

    pipe_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .NOP    (NOPV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #50000;
        $display("FAIL timeout obs=still_running exp=finished");
        $fatal(1, "time limit reached");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end else begin
            $display("chk  %s obs=%h exp=%h ok", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got [$];
    int          idx;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush_mask = '0;

        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data",  out_data,       NOPV);
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_occupancy", 32'(occupancy), 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        cyc();
        in_data   = 32'h2;
        cyc();
        in_data   = 32'h3;
        cyc();
        in_valid  = 1'b0;
        #1;
        check_val("str_occ_peak",   32'(occupancy), 32'd3);
        check_val("str_early_vld",  32'(out_valid), 32'd0);
        cyc();
        check_val("str_vld0",  32'(out_valid), 32'd1);
        check_val("str_dat0",  out_data,       32'h1);
        check_val("str_occ0",  32'(occupancy), 32'd3);
        cyc();
        check_val("str_dat1",  out_data,       32'h2);
        check_val("str_occ1",  32'(occupancy), 32'd2);
        cyc();
        check_val("str_dat2",  out_data,       32'h3);
        check_val("str_occ2",  32'(occupancy), 32'd1);
        cyc();
        check_val("str_vld_end", 32'(out_valid), 32'd0);
        check_val("str_dat_end", out_data,       NOPV);
        check_val("str_occ_end", 32'(occupancy), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        idx = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(idx);
            #1;
            if (in_ready) idx++;
            cyc();
        end
        #1;
        check_val("bp_accepted", 32'(idx - 1),   32'd4);
        check_val("bp_in_ready", 32'(in_ready),  32'd0);
        check_val("bp_occ_full", 32'(occupancy), 32'd4);
        out_ready = 1'b1;
        #1;
        check_val("bp_full_drain_rdy", 32'(in_ready), 32'd1);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            in_valid = (idx <= 6);
            in_data  = 32'(idx);
            #1;
            if (out_valid) got.push_back(out_data);
            if (in_valid && in_ready) idx++;
            cyc();
        end
        in_valid = 1'b0;
        check_val("bp_out_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            check_val($sformatf("bp_out%0d", i), got[i], 32'(i + 1));
        end

        // ---------------- bubble collapse ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1;
        cyc();
        in_valid  = 1'b0;
        cyc();
        cyc();
        in_valid  = 1'b1;
        in_data   = 32'hB2;
        cyc();
        in_valid  = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
        check_val("bub_out_data",  out_data,        32'hA1);
        check_val("bub_stage2",    dut.data_q[2],   32'hB2);
        check_val("bub_valid",     32'(dut.valid_q), 32'b1100);
        check_val("bub_occ",       32'(occupancy),  32'd2);
        check_val("bub_in_ready",  32'(in_ready),   32'd1);
        out_ready = 1'b1;
        cyc();
        check_val("bub_next_out",  out_data,        32'hB2);
        cyc();
        check_val("bub_drained",   32'(out_valid),  32'd0);

        // ---------------- partial flush ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(i);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check_val("fl_occ_full", 32'(occupancy), 32'd4);
        flush_mask = 4'b0110;
        out_ready  = 1'b1;
        #1;
        check_val("fl_emit_vld", 32'(out_valid), 32'd1);
        check_val("fl_emit_dat", out_data,       32'hA);
        cyc();
        flush_mask = '0;
        #1;
        check_val("fl_occ_after", 32'(occupancy), 32'd1);
        check_val("fl_stage2_nop", dut.data_q[2], NOPV);
        check_val("fl_stage1_d",   dut.data_q[1], 32'hD);
        check_val("fl_out_nop",    out_data,      NOPV);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i == 0);
            in_data  = 32'hE;
            #1;
            if (out_valid) got.push_back(out_data);
            cyc();
        end
        in_valid = 1'b0;
        check_val("fl_out_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check_val("fl_out_first",  got[0], 32'hD);
            check_val("fl_out_second", got[1], 32'hE);
        end

        // ---------------- full flush with accept ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 + 32'(i);
            cyc();
        end
        flush_mask = 4'b1111;
        in_valid   = 1'b1;
        in_data    = 32'hAA;
        #1;
        check_val("ff_in_ready",  32'(in_ready),  32'd1);
        check_val("ff_out_valid", 32'(out_valid), 32'd0);
        cyc();
        flush_mask = '0;
        in_valid   = 1'b0;
        #1;
        check_val("ff_occ",       32'(occupancy),   32'd1);
        check_val("ff_valid",     32'(dut.valid_q), 32'b0001);
        check_val("ff_stage0",    dut.data_q[0],    32'hAA);
        check_val("ff_out_valid2", 32'(out_valid),  32'd0);
        check_val("ff_out_data",  out_data,         NOPV);
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check_val("ff_aa_out", out_data, 32'hAA);
        cyc();
        check_val("ff_empty", 32'(occupancy), 32'd0);

        // ---------------- async reset mid-stream ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h31 + 32'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check_val("ar_pre_vld", 32'(out_valid), 32'd1);
        check_val("ar_pre_dat", out_data,       32'h31);
        #2 rst = 1'b0;
        #1;
        check_val("ar_out_valid", 32'(out_valid), 32'd0);
        check_val("ar_occ",       32'(occupancy), 32'd0);
        check_val("ar_out_data",  out_data,       NOPV);
        check_val("ar_in_ready",  32'(in_ready),  32'd1);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_valid) got.push_back(out_data);
        end
        check_val("ar_no_stale", 32'(got.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        check_val("ar_new_vld", 32'(out_valid), 32'd1);
        check_val("ar_new_dat", out_data,       32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
